// File: rtl/csr_pkg.sv
// CSR address map, field masks and privilege encodings shared by the CSR file.
package csr_pkg;

  // Supervisor CSRs
  localparam logic [11:0] CSR_SSTATUS   = 12'h100;
  localparam logic [11:0] CSR_SIE       = 12'h104;
  localparam logic [11:0] CSR_STVEC     = 12'h105;
  localparam logic [11:0] CSR_SEPC      = 12'h141;
  localparam logic [11:0] CSR_SCAUSE    = 12'h142;
  localparam logic [11:0] CSR_STVAL     = 12'h143;
  localparam logic [11:0] CSR_SIP       = 12'h144;
  localparam logic [11:0] CSR_SATP      = 12'h180;

  // Machine CSRs
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MEDELEG   = 12'h302;
  localparam logic [11:0] CSR_MIDELEG   = 12'h303;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;

  // Machine counters and their read-only user aliases
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // Machine information registers
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] SSTATUS_MASK  = 32'h000C_0122;
  localparam logic [31:0] MIP_WMASK     = 32'h0000_0022;
  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  // Reserved encoding 2'b10 collapses to user mode.
  function automatic priv_e priv_decode(input logic [1:0] p);
    case (p)
      2'b01:   return PRIV_S;
      2'b11:   return PRIV_M;
      default: return PRIV_U;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter with independent low/high half write ports.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  // Any half-write replaces the increment for that cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (we_lo_i || we_hi_i) begin
      if (we_lo_i) cnt_d[31:0]  = wdata_i;
      if (we_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine/supervisor CSR file: instruction and trap write ports, privilege, mcycle/minstret.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h8000_0000,
  parameter logic [31:0] MISA_VAL  = 32'h4014_1101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_csr_re_i,
  input  logic        inst_csr_we_i,
  input  logic [11:0] inst_csr_addr_i,
  input  logic [31:0] inst_csr_wdata_i,
  output logic [31:0] inst_csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_csr_we_i,
  input  logic [11:0] trap_csr_addr_i,
  input  logic [31:0] trap_csr_wdata_i,
  input  logic        priv_we_i,
  input  logic [1:0]  priv_i,
  input  logic        instret_i,
  input  logic        mtip_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic [31:0] csr_mtval_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_medeleg_o,
  output logic [31:0] csr_mideleg_o,
  output logic [31:0] csr_stvec_o,
  output logic [31:0] csr_sepc_o,
  output logic [31:0] csr_scause_o,
  output logic [31:0] csr_stval_o,
  output logic [31:0] csr_sstatus_o,
  output logic [31:0] csr_sie_o,
  output logic [31:0] csr_sip_o,
  output logic [31:0] csr_satp_o,
  output logic [1:0]  csr_privilege_o
);

  logic [31:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d, mie_q, mie_d;
  logic [31:0] mip_q, mip_d, medeleg_q, medeleg_d, mideleg_q, mideleg_d;
  logic [31:0] stvec_q, stvec_d, sepc_q, sepc_d, scause_q, scause_d;
  logic [31:0] stval_q, stval_d, satp_q, satp_d;
  logic        mtip_q, mtip_d;
  priv_e       priv_q, priv_d;

  logic [63:0] mcycle, minstret;
  logic        cyc_we_lo, cyc_we_hi, ins_we_lo, ins_we_hi;
  logic [31:0] mip_rd, sstatus_rd, sie_rd, sip_rd, rdata_raw;
  logic        impl, ro, illegal;
  logic [1:0]  cur_priv;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  assign cur_priv   = priv_q;
  assign mip_rd     = (mip_q & MIP_WMASK) | {24'b0, mtip_q, 7'b0};
  assign sstatus_rd = mstatus_q & SSTATUS_MASK;
  assign sie_rd     = mie_q & mideleg_q;
  assign sip_rd     = mip_rd & mideleg_q;

  // Read mux and legality decode for the instruction-side address.
  always_comb begin
    rdata_raw = '0;
    impl      = 1'b1;
    ro        = 1'b0;
    case (inst_csr_addr_i)
      CSR_SSTATUS:   rdata_raw = sstatus_rd;
      CSR_SIE:       rdata_raw = sie_rd;
      CSR_STVEC:     rdata_raw = stvec_q;
      CSR_SEPC:      rdata_raw = sepc_q;
      CSR_SCAUSE:    rdata_raw = scause_q;
      CSR_STVAL:     rdata_raw = stval_q;
      CSR_SIP:       rdata_raw = sip_rd;
      CSR_SATP:      rdata_raw = satp_q;
      CSR_MSTATUS:   rdata_raw = mstatus_q;
      CSR_MISA:      begin rdata_raw = MISA_VAL; ro = 1'b1; end
      CSR_MEDELEG:   rdata_raw = medeleg_q;
      CSR_MIDELEG:   rdata_raw = mideleg_q;
      CSR_MIE:       rdata_raw = mie_q;
      CSR_MTVEC:     rdata_raw = mtvec_q;
      CSR_MEPC:      rdata_raw = mepc_q;
      CSR_MCAUSE:    rdata_raw = mcause_q;
      CSR_MTVAL:     rdata_raw = mtval_q;
      CSR_MIP:       rdata_raw = mip_rd;
      CSR_MCYCLE,
      CSR_CYCLE:     rdata_raw = mcycle[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:    rdata_raw = mcycle[63:32];
      CSR_MINSTRET,
      CSR_INSTRET:   rdata_raw = minstret[31:0];
      CSR_MINSTRETH,
      CSR_INSTRETH:  rdata_raw = minstret[63:32];
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:    rdata_raw = '0;
      CSR_MHARTID:   rdata_raw = HART_ID;
      default:       impl = 1'b0;
    endcase
    illegal = (inst_csr_re_i | inst_csr_we_i) &
              (~impl | (inst_csr_addr_i[9:8] > cur_priv) |
               (inst_csr_we_i & ((inst_csr_addr_i[11:10] == 2'b11) | ro)));
    inst_csr_rdata_o = illegal ? '0 : rdata_raw;
    csr_illegal_o    = illegal;
  end

  // Write arbitration and per-CSR next-state; the trap port wins and is never checked.
  always_comb begin
    wr_en     = trap_csr_we_i | (inst_csr_we_i & ~illegal);
    wr_addr   = trap_csr_we_i ? trap_csr_addr_i  : inst_csr_addr_i;
    wr_data   = trap_csr_we_i ? trap_csr_wdata_i : inst_csr_wdata_i;
    mstatus_d = mstatus_q;  mtvec_d   = mtvec_q;   mepc_d    = mepc_q;
    mcause_d  = mcause_q;   mtval_d   = mtval_q;   mie_d     = mie_q;
    mip_d     = mip_q;      medeleg_d = medeleg_q; mideleg_d = mideleg_q;
    stvec_d   = stvec_q;    sepc_d    = sepc_q;    scause_d  = scause_q;
    stval_d   = stval_q;    satp_d    = satp_q;
    cyc_we_lo = 1'b0;       cyc_we_hi = 1'b0;
    ins_we_lo = 1'b0;       ins_we_hi = 1'b0;
    mtip_d    = mtip_i;
    priv_d    = priv_we_i ? priv_decode(priv_i) : priv_q;
    if (wr_en) begin
      case (wr_addr)
        CSR_SSTATUS:   mstatus_d = (mstatus_q & ~SSTATUS_MASK) | (wr_data & SSTATUS_MASK);
        CSR_SIE:       mie_d     = (mie_q & ~mideleg_q) | (wr_data & mideleg_q);
        CSR_STVEC:     stvec_d   = wr_data & ~32'h2;
        CSR_SEPC:      sepc_d    = wr_data & ~32'h3;
        CSR_SCAUSE:    scause_d  = wr_data;
        CSR_STVAL:     stval_d   = wr_data;
        CSR_SIP:       mip_d     = (mip_q & ~(mideleg_q & MIP_WMASK)) |
                                   (wr_data & mideleg_q & MIP_WMASK);
        CSR_SATP:      satp_d    = wr_data;
        CSR_MSTATUS:   mstatus_d = wr_data;
        CSR_MEDELEG:   medeleg_d = wr_data;
        CSR_MIDELEG:   mideleg_d = wr_data;
        CSR_MIE:       mie_d     = wr_data;
        CSR_MTVEC:     mtvec_d   = wr_data & ~32'h2;
        CSR_MEPC:      mepc_d    = wr_data & ~32'h3;
        CSR_MCAUSE:    mcause_d  = wr_data;
        CSR_MTVAL:     mtval_d   = wr_data;
        CSR_MIP:       mip_d     = wr_data & MIP_WMASK;
        CSR_MCYCLE:    cyc_we_lo = 1'b1;
        CSR_MCYCLEH:   cyc_we_hi = 1'b1;
        CSR_MINSTRET:  ins_we_lo = 1'b1;
        CSR_MINSTRETH: ins_we_hi = 1'b1;
        default:       ;
      endcase
    end
  end

  // CSR storage with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= MTVEC_RST;
      mepc_q    <= '0;  mcause_q  <= '0;  mtval_q   <= '0;
      mie_q     <= '0;  mip_q     <= '0;  medeleg_q <= '0;
      mideleg_q <= '0;  stvec_q   <= '0;  sepc_q    <= '0;
      scause_q  <= '0;  stval_q   <= '0;  satp_q    <= '0;
      mtip_q    <= 1'b0;
      priv_q    <= PRIV_M;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;    mcause_q  <= mcause_d;  mtval_q   <= mtval_d;
      mie_q     <= mie_d;     mip_q     <= mip_d;     medeleg_q <= medeleg_d;
      mideleg_q <= mideleg_d; stvec_q   <= stvec_d;   sepc_q    <= sepc_d;
      scause_q  <= scause_d;  stval_q   <= stval_d;   satp_q    <= satp_d;
      mtip_q    <= mtip_d;
      priv_q    <= priv_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .we_lo_i (cyc_we_lo),
    .we_hi_i (cyc_we_hi),
    .wdata_i (wr_data),
    .cnt_o   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (instret_i),
    .we_lo_i (ins_we_lo),
    .we_hi_i (ins_we_hi),
    .wdata_i (wr_data),
    .cnt_o   (minstret)
  );

  assign csr_mstatus_o   = mstatus_q;
  assign csr_mtvec_o     = mtvec_q;
  assign csr_mepc_o      = mepc_q;
  assign csr_mcause_o    = mcause_q;
  assign csr_mtval_o     = mtval_q;
  assign csr_mie_o       = mie_q;
  assign csr_mip_o       = mip_rd;
  assign csr_medeleg_o   = medeleg_q;
  assign csr_mideleg_o   = mideleg_q;
  assign csr_stvec_o     = stvec_q;
  assign csr_sepc_o      = sepc_q;
  assign csr_scause_o    = scause_q;
  assign csr_stval_o     = stval_q;
  assign csr_sstatus_o   = sstatus_rd;
  assign csr_sie_o       = sie_rd;
  assign csr_sip_o       = sip_rd;
  assign csr_satp_o      = satp_q;
  assign csr_privilege_o = cur_priv;

endmodule
